// File: rtl/alu_nibble_seq.sv
// Nibble-serial sequencer for the shared 4-bit ALU.
// Runs full-width ALU instructions low nibble first and returns result plus Z/N/H/C.
module alu_nibble_seq #(
  parameter int NIBBLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_op,
  input  logic [4*NIBBLES-1:0] req_a,
  input  logic [4*NIBBLES-1:0] req_b,
  input  logic                 req_c,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [4*NIBBLES-1:0] rsp_result,
  output logic                 rsp_we,
  output logic [3:0]           rsp_flags,
  output logic [3:0]           alu_in_A,
  output logic [3:0]           alu_in_B,
  output logic [2:0]           alu_op,
  output logic                 alu_in_C,
  input  logic [3:0]           alu_out,
  input  logic                 alu_out_Z,
  input  logic                 alu_out_C
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_CP  = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [IW-1:0] idx;
  logic [2:0]    op_q;
  logic [W-1:0]  a_sh, b_sh, res;
  logic [W+3:0]  res_cat;
  logic          zacc, h_q;
  logic          accept, last;
  logic          is_add, is_sub, is_logic;
  logic          z_nx, h_nx, c_nx;
  logic [2:0]    chain_op;

  assign accept     = req_valid & req_ready;
  assign last       = (idx == IW'(NIBBLES - 1));
  assign res_cat    = {alu_out, res};
  assign rsp_result = res;

  always_comb begin
    is_add   = 1'b0;
    is_sub   = 1'b0;
    is_logic = 1'b0;
    unique case (1'b1)
      (op_q == OP_ADD) || (op_q == OP_ADC): is_add = 1'b1;
      (op_q == OP_SUB) || (op_q == OP_SBC) ||
      (op_q == OP_CP):                      is_sub = 1'b1;
      default:                              is_logic = 1'b1;
    endcase
  end

  // Upper nibbles continue the chain with the carry/borrow flavour of the op.
  always_comb begin
    chain_op = op_q;
    unique case (1'b1)
      is_add:  chain_op = OP_ADC;
      is_sub:  chain_op = OP_SBC;
      default: chain_op = op_q;
    endcase
  end

  always_comb begin
    z_nx = (idx == '0) ? alu_out_Z : (zacc & alu_out_Z);
    h_nx = h_q;
    if (idx == '0) h_nx = is_logic ? (op_q == OP_AND) : alu_out_C;
    c_nx = is_logic ? 1'b0 : alu_out_C;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = RUN;
      end
      RUN: if (last) state_nx = DONE;
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      op_q      <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      res       <= '0;
      zacc      <= 1'b0;
      h_q       <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_flags <= '0;
      alu_in_A  <= '0;
      alu_in_B  <= '0;
      alu_op    <= '0;
      alu_in_C  <= 1'b0;
    end else if (accept) begin
      idx      <= '0;
      op_q     <= req_op;
      a_sh     <= req_a >> 4;
      b_sh     <= req_b >> 4;
      alu_in_A <= req_a[3:0];
      alu_in_B <= req_b[3:0];
      alu_op   <= req_op;
      alu_in_C <= req_c;
    end else if (state == RUN) begin
      // Nibbles shift in from the top so the low nibble lands at bit 0.
      res  <= res_cat[W+3:4];
      zacc <= z_nx;
      h_q  <= h_nx;
      if (last) begin
        rsp_flags <= {z_nx, is_sub, h_nx, c_nx};
        rsp_we    <= (op_q != OP_CP);
      end else begin
        idx      <= idx + 1'b1;
        a_sh     <= a_sh >> 4;
        b_sh     <= b_sh >> 4;
        alu_in_A <= a_sh[3:0];
        alu_in_B <= b_sh[3:0];
        alu_op   <= chain_op;
        alu_in_C <= is_logic ? 1'b0 : alu_out_C;
      end
    end
  end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Bench for alu_nibble_seq: 4-bit ALU model, full-width reference
// model feeding a scoreboard queue, directed plus a few random ops.
module tb_alu_nibble_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready;
  logic [2:0] req_op;
  logic [7:0] req_a, req_b;
  logic       req_c;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_we;
  logic [3:0] rsp_flags;
  logic [3:0] alu_in_A, alu_in_B, alu_out;
  logic [2:0] alu_op;
  logic       alu_in_C, alu_out_Z, alu_out_C;

  typedef struct packed {
    logic [7:0] res;
    logic       we;
    logic [3:0] fl;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic [4:0] t;

  always #5 clk = ~clk;

  alu_nibble_seq #(.NIBBLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_we(rsp_we), .rsp_flags(rsp_flags),
    .alu_in_A(alu_in_A), .alu_in_B(alu_in_B),
    .alu_op(alu_op), .alu_in_C(alu_in_C),
    .alu_out(alu_out), .alu_out_Z(alu_out_Z), .alu_out_C(alu_out_C)
  );

  // 4-bit ALU: C is carry for add ops, borrow for sub ops.
  always_comb begin
    t = '0;
    case (alu_op)
      3'd0: t = {1'b0, alu_in_A} + {1'b0, alu_in_B};
      3'd1: t = {1'b0, alu_in_A} + {1'b0, alu_in_B} + 5'(alu_in_C);
      3'd2: t = {1'b0, alu_in_A} - {1'b0, alu_in_B};
      3'd3: t = {1'b0, alu_in_A} - {1'b0, alu_in_B} - 5'(alu_in_C);
      3'd4: t = {1'b0, alu_in_A & alu_in_B};
      3'd5: t = {1'b0, alu_in_A ^ alu_in_B};
      3'd6: t = {1'b0, alu_in_A | alu_in_B};
      default: t = {1'b0, alu_in_A} - {1'b0, alu_in_B};
    endcase
    alu_out   = t[3:0];
    alu_out_C = t[4];
    alu_out_Z = (t[3:0] == 4'h0);
  end

  function automatic exp_t model(input logic [2:0] op,
                                 input logic [7:0] a, b,
                                 input logic c);
    exp_t e;
    logic [8:0] s;
    logic [4:0] hs;
    logic ci;
    e  = '0;
    ci = (op == 3'd1 || op == 3'd3) ? c : 1'b0;
    e.we = (op != 3'd7);
    case (op)
      3'd0, 3'd1: begin
        s  = {1'b0, a} + {1'b0, b} + 9'(ci);
        hs = {1'b0, a[3:0]} + {1'b0, b[3:0]} + 5'(ci);
        e.res = s[7:0];
        e.fl  = {s[7:0] == 8'h00, 1'b0, hs[4], s[8]};
      end
      3'd4: begin
        e.res = a & b;
        e.fl  = {e.res == 8'h00, 3'b010};
      end
      3'd5: begin
        e.res = a ^ b;
        e.fl  = {e.res == 8'h00, 3'b000};
      end
      3'd6: begin
        e.res = a | b;
        e.fl  = {e.res == 8'h00, 3'b000};
      end
      default: begin
        s  = {1'b0, a} - {1'b0, b} - 9'(ci);
        hs = {1'b0, a[3:0]} - {1'b0, b[3:0]} - 5'(ci);
        e.res = s[7:0];
        e.fl  = {s[7:0] == 8'h00, 1'b1, hs[4], s[8]};
      end
    endcase
    return e;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got, exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] op,
                        input logic [7:0] a, b,
                        input logic c, input int hold);
    exp_t e;
    int n;
    logic [7:0] sr;
    logic [3:0] sf;
    logic sw;
    n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    check("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    req_c = c;
    q.push_back(model(op, a, b, c));
    step();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    check("latency", 32'(n), 32'd2);
    sr = rsp_result;
    sf = rsp_flags;
    sw = rsp_we;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_op = 3'd5;
      req_a = 8'hFF;
      req_b = 8'h11;
      step();
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_ready", 32'(req_ready), 32'd0);
      check("hold_res", 32'(rsp_result), 32'(sr));
      check("hold_flags", 32'(rsp_flags), 32'(sf));
      check("hold_we", 32'(rsp_we), 32'(sw));
    end
    req_valid = 1'b0;
    if (q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      check("result", 32'(rsp_result), 32'(e.res));
      check("flags", 32'(rsp_flags), 32'(e.fl));
      check("we", 32'(rsp_we), 32'(e.we));
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("post_valid", 32'(rsp_valid), 32'd0);
    check("post_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    req_c = 1'b0;
    rsp_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_result", 32'(rsp_result), 32'd0);
    check("rst_flags", 32'(rsp_flags), 32'd0);
    check("rst_we", 32'(rsp_we), 32'd0);
    check("rst_alu_a", 32'(alu_in_A), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);

    run_op(3'd0, 8'h3A, 8'hC6, 1'b0, 0);
    run_op(3'd2, 8'h10, 8'h01, 1'b0, 0);
    run_op(3'd3, 8'h00, 8'h00, 1'b1, 0);
    run_op(3'd1, 8'hFF, 8'h00, 1'b1, 0);
    run_op(3'd7, 8'h42, 8'h42, 1'b0, 0);
    run_op(3'd4, 8'hF0, 8'h0F, 1'b0, 0);
    run_op(3'd6, 8'h00, 8'h00, 1'b0, 0);
    run_op(3'd5, 8'h5A, 8'hFF, 1'b0, 0);
    run_op(3'd0, 8'h0F, 8'h01, 1'b1, 4);

    // Abort an op after its first nibble.
    req_valid = 1'b1;
    req_op = 3'd0;
    req_a = 8'h77;
    req_b = 8'h88;
    step();
    req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_valid", 32'(rsp_valid), 32'd0);
    run_op(3'd2, 8'h23, 8'h45, 1'b0, 0);

    for (int i = 0; i < 8; i++) begin
      run_op(3'($urandom_range(7)), 8'($urandom), 8'($urandom),
             1'($urandom), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
